// File: rtl/uart_send_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_send_if
//  Purpose  : Write-side handshake between a byte producer and uart_send.
//             The master drives the write strobe and byte. The slave returns
//             uart_ready, which is high while the holding register is empty.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_send_if;
    logic       uart_en;
    logic [7:0] uart_din;
    logic       uart_ready;

    modport master (
        output uart_en,
        output uart_din,
        input  uart_ready
    );

    modport slave (
        input  uart_en,
        input  uart_din,
        output uart_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_send.sv
`default_nettype none
// ============================================================================
//  Module   : uart_send
//  Purpose  : 8N1 UART transmitter with a one-byte holding register. A byte
//             that is queued during a frame starts on the same edge that ends
//             the current stop bit, so back-to-back frames have no idle gap.
//             Defining UART_TX_PARITY_EN inserts a parity bit after D7. The
//             parity is even when PARITY_ODD=0 and odd when PARITY_ODD=1.
//  Revision : 1.0  initial release
// ============================================================================
module uart_send #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int BPS_CNT    = CLK_FREQ / UART_BPS,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    uart_send_if.slave  bus,
    output logic        uart_tx_busy,
    output logic        uart_tx_done,
    output logic        uart_txd
);

    localparam logic [15:0] c_bps_last   = 16'(BPS_CNT - 1);
    localparam logic [3:0]  c_last_bit   = 4'd7;

    localparam logic [2:0]  c_st_idle    = 3'd0;
    localparam logic [2:0]  c_st_start   = 3'd1;
    localparam logic [2:0]  c_st_data    = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0]  c_st_parity  = 3'd3;
`endif
    localparam logic [2:0]  c_st_stop    = 3'd4;

    logic [2:0]  state_q,      state_d;
    logic [7:0]  hold_data_q,  hold_data_d;
    logic        hold_valid_q, hold_valid_d;
    logic [7:0]  shift_q,      shift_d;
    logic [15:0] clk_cnt_q,    clk_cnt_d;
    logic [3:0]  bit_cnt_q,    bit_cnt_d;
    logic        txd_q,        txd_d;
    logic        busy_q,       busy_d;
    logic        done_q,       done_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q,     parity_d;
`else
    // Parity sense has no meaning without the parity bit.
    logic        w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD;
`endif

    // Last cycle of the current bit period.
    logic w_bit_end;
    // Holding register is moved into the shifter this edge: either from
    // idle, or straight from the end of a stop bit for a gapless next frame.
    logic w_load;

    assign w_bit_end = (clk_cnt_q == c_bps_last);
    assign w_load    = hold_valid_q &&
                       ((state_q == c_st_idle) || ((state_q == c_st_stop) && w_bit_end));

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= c_st_idle;
            hold_data_q  <= 8'd0;
            hold_valid_q <= 1'b0;
            shift_q      <= 8'd0;
            clk_cnt_q    <= 16'd0;
            bit_cnt_q    <= 4'd0;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            txd_q        <= txd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Next-state logic: every non-idle state holds for one full bit period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (hold_valid_q) begin
                    state_d = c_st_start;
                end
            end
            c_st_start: begin
                if (w_bit_end) begin
                    state_d = c_st_data;
                end
            end
            c_st_data: begin
                if (w_bit_end && (bit_cnt_q == c_last_bit)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = c_st_parity;
`else
                    state_d = c_st_stop;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            c_st_parity: begin
                if (w_bit_end) begin
                    state_d = c_st_stop;
                end
            end
`endif
            c_st_stop: begin
                if (w_bit_end) begin
                    state_d = hold_valid_q ? c_st_start : c_st_idle;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Output and datapath logic: line level, counters, holding register.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        txd_d        = txd_q;
        done_d       = 1'b0;
        busy_d       = (state_d != c_st_idle);
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        if ((state_q == c_st_idle) || w_bit_end) begin
            clk_cnt_d = 16'd0;
        end else begin
            clk_cnt_d = clk_cnt_q + 16'd1;
        end

        // A write is accepted only into an empty holding register. A write
        // on the same edge as a consume is dropped, because hold_valid_q is
        // still set on that edge.
        if (bus.uart_en && !hold_valid_q) begin
            hold_data_d  = bus.uart_din;
            hold_valid_d = 1'b1;
        end

        if (w_bit_end) begin
            case (state_q)
                c_st_start: begin
                    txd_d     = shift_q[0];
                    bit_cnt_d = 4'd0;
                end
                c_st_data: begin
                    if (bit_cnt_q == c_last_bit) begin
`ifdef UART_TX_PARITY_EN
                        txd_d = parity_q;
`else
                        txd_d = 1'b1;
`endif
                    end else begin
                        txd_d     = shift_q[1];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_st_parity: begin
                    txd_d = 1'b1;
                end
`endif
                c_st_stop: begin
                    done_d = 1'b1;
                end
                default: begin
                    txd_d = txd_q;
                end
            endcase
        end

        // Start a frame from the holding register. This overrides the
        // stop-bit level, so the next start bit begins without an idle cycle.
        if (w_load) begin
            hold_valid_d = 1'b0;
            shift_d      = hold_data_q;
            bit_cnt_d    = 4'd0;
            txd_d        = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d     = (^hold_data_q) ^ PARITY_ODD;
`endif
        end
    end

    assign bus.uart_ready = ~hold_valid_q;
    assign uart_txd       = txd_q;
    assign uart_tx_busy   = busy_q;
    assign uart_tx_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_send.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_send
//  Purpose  : Directed, table-driven bench for uart_send with BPS_CNT = 10.
//             Each expected line pattern is {stop, D7..D0, start}, and the
//             even parity of each byte is listed next to it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_send;

    localparam bit c_par_odd = 1'b0;

    logic sys_clk;
    logic sys_rst_n;
    logic uart_tx_busy;
    logic uart_tx_done;
    logic uart_txd;

    int n_checks = 0;
    int n_errors = 0;

    uart_send_if u_if ();

    uart_send #(
        .CLK_FREQ   (1000000),
        .UART_BPS   (100000),
        .PARITY_ODD (c_par_odd)
    ) u_dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .bus          (u_if),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_done (uart_tx_done),
        .uart_txd     (uart_txd)
    );

    // Clock generation: 10 time units per cycle.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Absolute time limit so that a stuck run still terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    typedef struct {
        logic [7:0] din;
        logic [9:0] line;
        logic       par;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Present one byte for exactly one clock edge, then scramble the data.
    task automatic strobe(input logic [7:0] d);
        u_if.uart_en  = 1'b1;
        u_if.uart_din = d;
        step();
        u_if.uart_en  = 1'b0;
        u_if.uart_din = 8'($urandom);
    endtask

    // Wait for the start fall, then check every cycle of the frame and the
    // done edge. The task returns at the sample just after the done edge.
    task automatic run_frame(input logic [9:0] line, input logic par,
                             input logic b2b, input string name);
        logic [10:0] bits;
        int          nb;
        int          t;
`ifdef UART_TX_PARITY_EN
        nb   = 11;
        bits = {line[9], par ^ c_par_odd, line[8:0]};
`else
        nb   = 10;
        bits = {1'b0, line};
        if (par === 1'bx) nb = 10;
`endif
        t = 0;
        while ((uart_txd !== 1'b0) && (t < 400)) begin
            step();
            t++;
        end
        if (uart_txd !== 1'b0) begin
            chk({name, " start timeout"}, 32'(uart_txd), 32'd0);
            return;
        end
        for (int c = 0; c < nb * 10; c++) begin
            chk({name, " txd"}, 32'(uart_txd), 32'(bits[c / 10]));
            chk({name, " busy"}, 32'(uart_tx_busy), 32'd1);
            if (c > 0) chk({name, " early done"}, 32'(uart_tx_done), 32'd0);
            step();
        end
        chk({name, " done"}, 32'(uart_tx_done), 32'd1);
        chk({name, " busy end"}, 32'(uart_tx_busy), 32'(b2b));
        chk({name, " txd end"}, 32'(uart_txd), b2b ? 32'd0 : 32'd1);
    endtask

    // Send one byte from idle and check latency, the frame and the return to idle.
    task automatic send_single(input vec_t v, input string name);
        strobe(v.din);
        chk({name, " ready after write"}, 32'(u_if.uart_ready), 32'd0);
        chk({name, " txd after write"}, 32'(uart_txd), 32'd1);
        chk({name, " busy after write"}, 32'(uart_tx_busy), 32'd0);
        step();
        chk({name, " ready after load"}, 32'(u_if.uart_ready), 32'd1);
        chk({name, " txd after load"}, 32'(uart_txd), 32'd0);
        chk({name, " busy after load"}, 32'(uart_tx_busy), 32'd1);
        run_frame(v.line, v.par, 1'b0, name);
        step();
        chk({name, " done width"}, 32'(uart_tx_done), 32'd0);
        chk({name, " idle txd"}, 32'(uart_txd), 32'd1);
        chk({name, " idle busy"}, 32'(uart_tx_busy), 32'd0);
    endtask

    initial begin
        u_if.uart_en  = 1'b0;
        u_if.uart_din = 8'h00;
        sys_rst_n     = 1'b0;

        vecs[0] = '{din: 8'h55, line: 10'b1010101010, par: 1'b0};
        vecs[1] = '{din: 8'h07, line: 10'b1000001110, par: 1'b1};
        vecs[2] = '{din: 8'h00, line: 10'b1000000000, par: 1'b0};
        vecs[3] = '{din: 8'hFF, line: 10'b1111111110, par: 1'b0};
        vecs[4] = '{din: 8'hC8, line: 10'b1110010000, par: 1'b1};
        vecs[5] = '{din: 8'h81, line: 10'b1100000010, par: 1'b0};

        // Reset held with the write strobe toggling: no write may be captured.
        u_if.uart_din = 8'hAA;
        for (int i = 0; i < 6; i++) begin
            u_if.uart_en = i[0] ? 1'b0 : 1'b1;
            step();
            chk("rst txd", 32'(uart_txd), 32'd1);
            chk("rst ready", 32'(u_if.uart_ready), 32'd1);
            chk("rst busy", 32'(uart_tx_busy), 32'd0);
            chk("rst done", 32'(uart_tx_done), 32'd0);
        end
        u_if.uart_en = 1'b0;
        sys_rst_n    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post-rst txd", 32'(uart_txd), 32'd1);
            chk("post-rst ready", 32'(u_if.uart_ready), 32'd1);
        end

        // Single frames from idle.
        for (int i = 0; i < 6; i++) begin
            send_single(vecs[i], $sformatf("vec%0d", i));
            repeat (3) step();
        end

        // Second byte queued mid-frame: zero idle gap between frames.
        fork
            begin
                strobe(8'hA3);
                repeat (30) step();
                strobe(8'h0F);
            end
            begin
                run_frame(10'b1101000110, 1'b0, 1'b1, "b2b A3");
                run_frame(10'b1000011110, 1'b0, 1'b0, "b2b 0F");
            end
        join
        step();
        chk("b2b done width", 32'(uart_tx_done), 32'd0);
        repeat (3) step();

        // Three writes in a row: the third hits a full holding register.
        fork
            begin
                strobe(8'h11);
                step();
                strobe(8'h22);
                chk("triple ready before 33", 32'(u_if.uart_ready), 32'd0);
                strobe(8'h33);
            end
            begin
                run_frame(10'b1000100010, 1'b0, 1'b1, "triple 11");
                run_frame(10'b1001000100, 1'b0, 1'b0, "triple 22");
            end
        join
        for (int i = 0; i < 40; i++) begin
            step();
            chk("no third frame txd", 32'(uart_txd), 32'd1);
            chk("no third frame done", 32'(uart_tx_done), 32'd0);
        end

        // Reset during data bit 3 of 0xF0, with another byte held.
        strobe(8'hF0);
        step();
        chk("F0 start", 32'(uart_txd), 32'd0);
        strobe(8'h3C);
        chk("F0 hold full", 32'(u_if.uart_ready), 32'd0);
        repeat (43) step();
        chk("F0 bit3", 32'(uart_txd), 32'd0);
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        chk("midrst txd", 32'(uart_txd), 32'd1);
        chk("midrst busy", 32'(uart_tx_busy), 32'd0);
        chk("midrst done", 32'(uart_tx_done), 32'd0);
        chk("midrst ready", 32'(u_if.uart_ready), 32'd1);
        for (int i = 0; i < 150; i++) begin
            step();
            chk("midrst quiet txd", 32'(uart_txd), 32'd1);
            chk("midrst quiet done", 32'(uart_tx_done), 32'd0);
        end
        send_single(vecs[5], "after rst 81");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
